// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD arithmetic blocks: FSM state
// encoding, BCD constants and small digit helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Widest operand get_digit() can index; callers zero-extend to this width.
  localparam int unsigned MAX_DIGITS = 32;

  // Nine's complement of a single BCD digit.
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

  // Extract BCD digit 'idx' (digit 0 = bits [3:0]) from a packed BCD vector.
  function automatic logic [3:0] get_digit(input logic [4*MAX_DIGITS-1:0] vec,
                                           input logic [4:0]              idx);
    return vec[4*idx +: 4];
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder with decimal (+6) correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  // Binary sum, then fold values above 9 back into the BCD range.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first or full if/else) so no latch is inferred.
    t = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    if (t > {1'b0, BCD_MAX}) begin
      s    = t[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: |A - B| plus sign, one digit per clock.
// CALC adds A to the nine's complement of B with an initial carry of 1; a
// missing final carry means the result is a ten's complement, which FIX turns
// back into a magnitude by a second nine's-complement-plus-one pass.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = 4 * MAX_DIGITS;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       diff_q, diff_d;
  logic               neg_q, neg_d;
  logic               invalid_q, invalid_d;

  logic               operand_bad;
  logic               last_digit;
  logic [3:0]         a_digit, b_digit, diff_digit;
  logic [3:0]         add_x, add_y, add_s;
  logic               add_cout;

  // Flag any non-BCD digit on the live operand inputs (checked at start).
  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) operand_bad = 1'b1;
    end
  end

  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign a_digit    = get_digit(EXT_W'(a_q), 5'(idx_q));
  assign b_digit    = get_digit(EXT_W'(b_q), 5'(idx_q));
  assign diff_digit = get_digit(EXT_W'(diff_q), 5'(idx_q));

  // One shared digit adder: CALC computes a_i + (9 - b_i), FIX computes
  // 0 + (9 - diff_i); the running carry supplies the +1 of both passes.
  assign add_x = (state_q == FIX) ? 4'd0 : a_digit;
  assign add_y = (state_q == FIX) ? nines_comp(diff_digit) : nines_comp(b_digit);

  bcd_digit_add u_digit_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          diff_d = '0;
          neg_d  = 1'b0;
          if (operand_bad) begin
            invalid_d = 1'b1;
            state_d   = DONE;
          end else begin
            invalid_d = 1'b0;
            carry_d   = 1'b1;
            idx_d     = '0;
            state_d   = CALC;
          end
        end
      end

      CALC, FIX: begin
        // Result digits are written in place at the current index.
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) diff_d[4*i +: 4] = add_s;
        end
        carry_d = add_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_digit) begin
          idx_d = '0;
          if (state_q == CALC && !add_cout) begin
            // No carry out of the top digit: A < B, diff holds a ten's complement.
            neg_d   = 1'b1;
            carry_d = 1'b1;
            state_d = FIX;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == CALC) || (state_q == FIX);
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule
